// File: rtl/vx_rop_dcr_queue.sv
// ROP DCR staging bank with a queue of committed render-output contexts.
// Writes land in a 12-register staging bank. A write to offset 12 (COMMIT)
// snapshots the bank into a circular FIFO of NUM_CTX contexts, which the
// consumer drains through a valid/ready handshake.
// Optional feature: define ROP_DCR_READBACK_EN to add a registered staging
// readback port (dcr_read_addr / dcr_read_data).

package vx_rop_dcr_pkg;

    typedef struct packed {
        logic       mask;
        logic [2:0] func;
    } rop_depth_t;

    typedef struct packed {
        logic [7:0] ref_val;
        logic [7:0] mask;
        logic [2:0] fail;
        logic [2:0] zfail;
        logic [2:0] zpass;
        logic [2:0] func;
    } rop_stencil_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] rgb;
    } rop_blend_mode_t;

    typedef struct packed {
        logic [3:0] dst_a;
        logic [3:0] dst_rgb;
        logic [3:0] src_a;
        logic [3:0] src_rgb;
    } rop_blend_func_t;

    typedef struct packed {
        logic [31:0]     cbuf_addr;
        logic [31:0]     cbuf_pitch;
        logic [31:0]     cbuf_mask;
        logic [31:0]     zbuf_addr;
        logic [31:0]     zbuf_pitch;
        rop_depth_t      depth;
        rop_stencil_t    stencil_front;
        rop_stencil_t    stencil_back;
        rop_blend_mode_t blend_mode;
        rop_blend_func_t blend_func;
        logic [31:0]     blend_const;
        logic [3:0]      logic_op;
    } rop_dcrs_t;

endpackage

module vx_rop_dcr_queue #(
    parameter int NUM_CTX   = 2,
    parameter int ADDR_BITS = 12,
    parameter int DCR_BASE  = 0,
    parameter int DCRS_W    = $bits(vx_rop_dcr_pkg::rop_dcrs_t)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dcr_write_valid,
    output logic                           dcr_write_ready,
    input  logic [ADDR_BITS-1:0]           dcr_write_addr,
    input  logic [31:0]                    dcr_write_data,
`ifdef ROP_DCR_READBACK_EN
    input  logic [ADDR_BITS-1:0]           dcr_read_addr,
    output logic [31:0]                    dcr_read_data,
`endif
    output logic                           ctx_valid,
    input  logic                           ctx_ready,
    output logic [DCRS_W-1:0]              ctx_dcrs,
    output logic [$clog2(NUM_CTX+1)-1:0]   ctx_count
);
    import vx_rop_dcr_pkg::*;

    localparam int PTR_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int CNT_W = $clog2(NUM_CTX+1);
    localparam logic [ADDR_BITS-1:0] BASE_A   = ADDR_BITS'(DCR_BASE);
    localparam logic [ADDR_BITS-1:0] NUM_OFFS = ADDR_BITS'(13);
    localparam logic [3:0]           OFF_COMMIT = 4'd12;

    rop_dcrs_t          stage_r;
    logic [DCRS_W-1:0]  ctx_q [NUM_CTX];
    logic [PTR_W-1:0]   head_r, tail_r;
    logic [CNT_W-1:0]   count_r;

    logic [ADDR_BITS-1:0] wr_rel;
    logic                 wr_hit, wr_fire, push, pop;
    logic [3:0]           wr_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CTX-1)) ? '0 : p + 1'b1;
    endfunction

    // Address decode relative to DCR_BASE; anything outside 0..12 is a no-op.
    always_comb begin
        wr_rel  = dcr_write_addr - BASE_A;
        wr_hit  = (dcr_write_addr >= BASE_A) && (wr_rel < NUM_OFFS);
        wr_idx  = wr_rel[3:0];
        wr_fire = dcr_write_valid && dcr_write_ready;
        push    = wr_fire && wr_hit && (wr_idx == OFF_COMMIT);
        pop     = ctx_valid && ctx_ready;
    end

    assign dcr_write_ready = (count_r != CNT_W'(NUM_CTX));
    assign ctx_valid       = (count_r != '0);
    assign ctx_count       = count_r;
    assign ctx_dcrs        = ctx_q[head_r];

    // Staging bank: fields take their packed slice of the write data; COMMIT leaves it intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_r <= '0;
        end else if (wr_fire && wr_hit) begin
            case (wr_idx)
                4'd0:  stage_r.cbuf_addr     <= dcr_write_data;
                4'd1:  stage_r.cbuf_pitch    <= dcr_write_data;
                4'd2:  stage_r.cbuf_mask     <= dcr_write_data;
                4'd3:  stage_r.zbuf_addr     <= dcr_write_data;
                4'd4:  stage_r.zbuf_pitch    <= dcr_write_data;
                4'd5:  stage_r.depth         <= rop_depth_t'(dcr_write_data[3:0]);
                4'd6:  stage_r.stencil_front <= rop_stencil_t'(dcr_write_data[27:0]);
                4'd7:  stage_r.stencil_back  <= rop_stencil_t'(dcr_write_data[27:0]);
                4'd8:  stage_r.blend_mode    <= rop_blend_mode_t'(dcr_write_data[5:0]);
                4'd9:  stage_r.blend_func    <= rop_blend_func_t'(dcr_write_data[15:0]);
                4'd10: stage_r.blend_const   <= dcr_write_data;
                4'd11: stage_r.logic_op      <= dcr_write_data[3:0];
                default: ;
            endcase
        end
    end

    // Context storage: written at the tail on COMMIT; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ctx_q[tail_r] <= DCRS_W'(stage_r);
        end
    end

    // Queue control: circular pointers and occupancy, push and pop in the same cycle allowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) tail_r <= next_ptr(tail_r);
            if (pop)  head_r <= next_ptr(head_r);
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef ROP_DCR_READBACK_EN
    logic [ADDR_BITS-1:0] rd_rel;
    logic                 rd_hit;
    logic [31:0]          rd_mux;

    // Readback mux: staging field zero-extended, COMMIT and out-of-range offsets read 0.
    always_comb begin
        rd_rel = dcr_read_addr - BASE_A;
        rd_hit = (dcr_read_addr >= BASE_A) && (rd_rel < NUM_OFFS);
        rd_mux = '0;
        if (rd_hit) begin
            case (rd_rel[3:0])
                4'd0:  rd_mux = stage_r.cbuf_addr;
                4'd1:  rd_mux = stage_r.cbuf_pitch;
                4'd2:  rd_mux = stage_r.cbuf_mask;
                4'd3:  rd_mux = stage_r.zbuf_addr;
                4'd4:  rd_mux = stage_r.zbuf_pitch;
                4'd5:  rd_mux = 32'(stage_r.depth);
                4'd6:  rd_mux = 32'(stage_r.stencil_front);
                4'd7:  rd_mux = 32'(stage_r.stencil_back);
                4'd8:  rd_mux = 32'(stage_r.blend_mode);
                4'd9:  rd_mux = 32'(stage_r.blend_func);
                4'd10: rd_mux = stage_r.blend_const;
                4'd11: rd_mux = 32'(stage_r.logic_op);
                default: rd_mux = '0;
            endcase
        end
    end

    // Registered readback, one cycle after the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            dcr_read_data <= '0;
        end else begin
            dcr_read_data <= rd_mux;
        end
    end
`endif

endmodule

// File: doc/vx_rop_dcr_queue.md
VX_ROP_DCR_QUEUE -- requirements
Module: VX_rop_dcr_queue

Interface
REQ-001 SHALL have parameter NUM_CTX, default 2: depth of the committed-context queue (≥1).
REQ-002 SHALL have parameter ADDR_BITS, default 12: DCR address width.
REQ-003 SHALL have parameter DCR_BASE, default 0: DCR address of register offset 0.
REQ-004 SHALL have parameter DCRS_W, default = packed ROP DCR struct width: width of one context.
REQ-005 SHALL use one clock and a synchronous, active-high reset; all state updates occur on the rising edge of clk.
REQ-006 SHALL have port clk  in  1  clock.
REQ-007 SHALL have port reset  in  1  synchronous active-high reset.
REQ-008 SHALL have port dcr_write_valid  in  1  DCR write request.
REQ-009 SHALL have port dcr_write_ready  out  1  write accepted.
REQ-010 SHALL have port dcr_write_addr  in  ADDR_BITS  DCR address.
REQ-011 SHALL have port dcr_write_data  in  32  DCR data.
REQ-012 SHALL have port ctx_valid  out  1  head context available.
REQ-013 SHALL have port ctx_ready  in  1  consumer releases head context.
REQ-014 SHALL have port ctx_dcrs  out  DCRS_W  head context, packed struct layout.
REQ-015 SHALL have port ctx_count  out  clog2(NUM_CTX+1)  committed contexts held.

Function
REQ-016 SHALL keep a staging bank of 12 registers at offsets 0-11 from DCR_BASE: 0 cbuf_addr, 1 cbuf_pitch, 2 cbuf_mask, 3 zbuf_addr, 4 zbuf_pitch, 10 blend_const, each 32 bits.
REQ-017 SHALL use these packed fields: 5 depth {[3] mask, [2:0] func}; 6/7 stencil front/back {[27:20] ref, [19:12] mask, [11:9] fail, [8:6] zfail, [5:3] zpass, [2:0] func}; 8 blend_mode {[5:3] a, [2:0] rgb}; 9 blend_func {[15:12] dst_a, [11:8] dst_rgb, [7:4] src_a, [3:0] src_rgb}; 11 logic_op [3:0]; unused data bits ignored.
REQ-018 SHALL treat offset 12 as COMMIT: an accepted write (any data) pushes the staging bank as one context into the queue tail.
REQ-019 SHALL accept a write on dcr_write_valid && dcr_write_ready; offsets >12 or below DCR_BASE are accepted and ignored.
REQ-020 SHALL drive dcr_write_ready = (ctx_count != NUM_CTX), stalling all writes while the queue is full.
REQ-021 SHALL leave the staging bank unchanged by COMMIT, so later contexts inherit unmodified fields.
REQ-022 SHALL update a staging register one cycle after an accepted write; a COMMIT in cycle N captures all writes accepted before N.
REQ-023 SHALL assert ctx_valid = (ctx_count != 0), with ctx_dcrs the oldest context held stable until popped.
REQ-024 SHALL pop the head on ctx_valid && ctx_ready; ctx_ready while empty has no effect.
REQ-025 SHALL have commit-to-visible latency of 1 cycle: a COMMIT accepted in cycle N on an empty queue gives ctx_valid=1 in N+1.
REQ-026 SHALL process a simultaneous accepted COMMIT and pop in one cycle, leaving ctx_count unchanged and the head advanced.
REQ-027 SHALL wrap its circular head/tail pointers modulo NUM_CTX, preserving FIFO order across wrap.

Reset
REQ-028 SHALL clear on reset: all staging registers to 0, head/tail pointers to 0, ctx_count=0, ctx_valid=0, dcr_write_ready=1.
REQ-029 SHALL discard all held contexts on reset asserted mid-operation, whatever the pending handshake.
REQ-030 SHALL not require ctx_dcrs to have any defined value while ctx_valid=0.

Configuration
REQ-031 SHALL, with ROP_DCR_READBACK_EN defined, add ports dcr_read_addr (in, ADDR_BITS) and dcr_read_data (out, 32).
REQ-032 SHALL, with ROP_DCR_READBACK_EN defined, register dcr_read_data one cycle after dcr_read_addr with the staging register in REQ-017 packing, unused bits 0 and offsets outside 0-11 reading 0.
REQ-033 SHALL, without ROP_DCR_READBACK_EN, omit the read ports and their logic entirely.

Verification
REQ-034 SHALL cover: write offset 0 = 0x8000_0000, then COMMIT -> next cycle ctx_valid=1, cbuf_addr field = 0x8000_0000, ctx_count=1.
REQ-035 SHALL cover: NUM_CTX=2, three COMMITs with ctx_ready=0 -> dcr_write_ready=0 after second; third accepted only after one pop.
REQ-036 SHALL cover: commit A (depth func=3), write depth func=5, commit B -> pops yield 3 then 5; cbuf fields identical in both.
REQ-037 SHALL cover: queue holding 1, COMMIT and ctx_ready same cycle -> ctx_count stays 1, head becomes the new context.
REQ-038 SHALL cover: reset asserted with 2 contexts held -> next cycle ctx_valid=0, ctx_count=0, readback offset 6 = 0.
REQ-039 SHALL cover: write offset 13 = 0xFFFF_FFFF -> accepted, no staging or queue change; stencil front write 0x0FFF_FFFF reads back unchanged.
